uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single UART transmit byte channel between NUM_REQ on-chip requesters.
//  Arbitration is round-robin at message granularity. A grant is held until the
//  requester's last byte is accepted, or until a per-message idle timeout expires.
//  Sits between firmware/DMA message sources and the UART TX FIFO in the UART top.
// PARAMETERS
//  NUM_REQ   4      number of requesters, 2..8
//  DATA_W    8      byte width of data path
//  TIMEOUT   1023   idle cycles tolerated mid-message before grant is revoked; 0 = never
//  ID_BASE   8'hA0  header byte base; header = ID_BASE + requester index (UART_ARB_ID_HEADER_EN only)
// PORTS
//  Clk         in   1                 system clock, all logic on rising edge
//  RstN        in   1                 asynchronous active-low reset
//  ReqValid    in   NUM_REQ           per-requester byte valid
//  ReqData     in   NUM_REQ*DATA_W    per-requester byte; requester i owns bits [i*DATA_W +: DATA_W]
//  ReqLast     in   NUM_REQ           marks final byte of a message; qualified by ReqValid
//  ReqReady    out  NUM_REQ           byte accepted from requester i when ReqValid[i] & ReqReady[i]
//  TxValid     out  1                 byte offered to UART TX FIFO
//  TxData      out  DATA_W            byte to UART TX FIFO
//  TxReady     in   1                 UART TX FIFO can accept; transfer = TxValid & TxReady
//  GrantId     out  $clog2(NUM_REQ)   index of current owner; valid while Busy
//  Busy        out  1                 high in any state other than IDLE
//  ErrTimeout  out  1                 one-cycle pulse when a grant is revoked by timeout
//  ErrCnt      out  8                 count of timeouts, saturates at 255
// BEHAVIOUR
//  Reset: state IDLE; TxValid=0, TxData=0, ReqReady=0, GrantId=0, Busy=0, ErrTimeout=0, ErrCnt=0.
//         LastGrant=NUM_REQ-1, so requester 0 wins the first contended arbitration.
//  FSM states: IDLE -> [HDR] -> DATA -> IDLE.
//  IDLE: if any ReqValid, pick first set bit searching LastGrant+1 upward, wrapping modulo NUM_REQ.
//    Register GrantId. Next state is HDR with the macro, DATA without it.
//    Latency is 1 cycle from ReqValid to the first TxValid. All outputs are 0 in IDLE.
//  DATA: TxValid=ReqValid[g], TxData=ReqData[g], ReqReady[g]=TxReady (combinational).
//    ReqReady of all other requesters is 0.
//    On a transfer with ReqLast[g]=1: LastGrant<=g and go to IDLE. No re-arbitration in the same cycle.
//  Requester rules: hold Data/Last stable while Valid & !Ready. Valid may drop between bytes.
//  Timeout: IdleCnt counts DATA cycles with ReqValid[g]=0 and clears on every transfer.
//    TxReady backpressure is never counted.
//    When IdleCnt reaches TIMEOUT: ErrTimeout pulses, ErrCnt increments (saturating at 255),
//    LastGrant<=g, and the FSM goes to IDLE. The UART sees a truncated message; no byte is lost or duplicated.
//  Simultaneous timeout-expiry cycle and ReqValid[g] rising: the transfer wins and IdleCnt clears.
//  A requester that drops ReqValid in IDLE before being granted is simply not selected. No stale grant.
//  Only one requester is active: it may be re-granted back-to-back; each message still costs 1 IDLE cycle.
//  Reset mid-message aborts immediately. The partial message is not resumed after reset.
// CONFIGURATION
//  UART_ARB_ID_HEADER_EN defined: the HDR state is present.
//    HDR: TxValid=1, TxData=ID_BASE+g, all ReqReady=0. Goes to DATA on TxReady.
//    The timeout counter is held at 0 in HDR. Each message on the UART is prefixed by one ID byte.
//  UART_ARB_ID_HEADER_EN undefined: HDR and the ID_BASE logic are removed. Messages pass through bare.
// TESTING
//  1. Req0 sends 3 bytes 11,22,33(Last), TxReady=1 -> TX sees 11,22,33; TxValid starts 1 cycle after ReqValid.
//  2. Req1 and Req3 raise ReqValid together after reset -> Req1 message completes first, then Req3; Req0 never granted.
//  3. Req2 stalls 1023 cycles mid-message, TIMEOUT=1023 -> ErrTimeout pulses once, ErrCnt=1, FSM IDLE, Req0 then granted.
//  4. TxReady=0 for 2000 cycles during Req0 message -> no timeout, ReqReady[0]=0 throughout, data resumes intact.
//  5. With UART_ARB_ID_HEADER_EN, Req2 sends 55(Last) -> TX sees A2,55; header stalls correctly under TxReady=0.
//  6. RstN asserted mid-message on Req1 -> outputs 0 asynchronously; after release, Req0 wins contention with Req1.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing one UART TX byte channel between NUM_REQ requesters.
// Optional ID header byte per message when UART_ARB_ID_HEADER_EN is defined.
module uart_tx_arbiter #(
    parameter int                NUM_REQ = 4,
    parameter int                DATA_W  = 8,
    parameter int                TIMEOUT = 1023,
    parameter logic [DATA_W-1:0] ID_BASE = 'hA0,
    localparam int               GID_W   = $clog2(NUM_REQ)
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  i_req_data,
    input  logic [NUM_REQ-1:0]         i_req_last,
    output logic [NUM_REQ-1:0]         o_req_ready,
    output logic                       o_tx_valid,
    output logic [DATA_W-1:0]          o_tx_data,
    input  logic                       i_tx_ready,
    output logic [GID_W-1:0]           o_grant_id,
    output logic                       o_busy,
    output logic                       o_err_timeout,
    output logic [7:0]                 o_err_cnt
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [GID_W-1:0]   r_grant;
    logic [GID_W-1:0]   r_last_grant;
    logic [CNT_W-1:0]   r_idle_cnt;
    logic [7:0]         r_err_cnt;

    logic               w_pick_found;
    logic [GID_W-1:0]   w_pick;
    logic               w_own_valid;
    logic               w_own_last;
    logic [DATA_W-1:0]  w_own_data;
    logic               w_xfer;
    logic               w_timeout;

    // Round-robin search starting just after the previous owner.
    always_comb begin
        int idx;
        w_pick_found = 1'b0;
        w_pick       = '0;
        idx          = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(r_last_grant) + k) % NUM_REQ;
            if (!w_pick_found && i_req_valid[idx]) begin
                w_pick_found = 1'b1;
                w_pick       = GID_W'(idx);
            end
        end
    end

    assign w_own_valid = i_req_valid[r_grant];
    assign w_own_last  = i_req_last[r_grant];
    assign w_own_data  = i_req_data[int'(r_grant)*DATA_W +: DATA_W];

    // Expiry only on an idle cycle, so a byte arriving on the final cycle still wins.
    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            assign w_timeout = 1'b0;
        end else begin : g_timeout
            assign w_timeout = (r_state == S_DATA) && !w_own_valid &&
                               (r_idle_cnt == CNT_W'(TIMEOUT - 1));
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        o_tx_valid  = 1'b0;
        o_tx_data   = '0;
        o_req_ready = '0;
        w_xfer      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pick_found) begin
`ifdef UART_ARB_ID_HEADER_EN
                    w_next = S_HDR;
`else
                    w_next = S_DATA;
`endif
                end
            end
`ifdef UART_ARB_ID_HEADER_EN
            S_HDR: begin
                o_tx_valid = 1'b1;
                o_tx_data  = ID_BASE + DATA_W'(r_grant);
                if (i_tx_ready) begin
                    w_next = S_DATA;
                end
            end
`endif
            S_DATA: begin
                o_tx_valid           = w_own_valid;
                o_tx_data            = w_own_data;
                o_req_ready[r_grant] = i_tx_ready;
                w_xfer               = w_own_valid & i_tx_ready;
                if ((w_xfer && w_own_last) || w_timeout) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_grant      <= '0;
            r_last_grant <= GID_W'(NUM_REQ - 1);
        end else begin
            if (r_state == S_IDLE && w_pick_found) begin
                r_grant <= w_pick;
            end
            if ((w_xfer && w_own_last) || w_timeout) begin
                r_last_grant <= r_grant;
            end
        end
    end

    // Backpressure (valid high, ready low) neither counts nor clears.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idle_cnt <= '0;
        end else if (r_state != S_DATA || w_xfer || w_timeout) begin
            r_idle_cnt <= '0;
        end else if (!w_own_valid) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err_cnt <= '0;
        end else if (w_timeout && r_err_cnt != 8'hFF) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign o_busy        = (r_state != S_IDLE);
    assign o_grant_id    = o_busy ? r_grant : '0;
    assign o_err_timeout = w_timeout;
    assign o_err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-requester drivers, expected-byte queue, negedge monitor.
module tb_uart_tx_arbiter;
    localparam int         NUM_REQ = 4;
    localparam int         DATA_W  = 8;
    localparam int         TIMEOUT = 1023;
    localparam logic [7:0] ID_BASE = 8'hA0;
`ifdef UART_ARB_ID_HEADER_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif

    logic                       clk;
    logic                       rst_n;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*DATA_W-1:0]  req_data;
    logic [NUM_REQ-1:0]         req_last;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       tx_valid;
    logic [DATA_W-1:0]          tx_data;
    logic                       tx_ready;
    logic [1:0]                 grant_id;
    logic                       busy;
    logic                       err_timeout;
    logic [7:0]                 err_cnt;

    uart_tx_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT),
        .ID_BASE (ID_BASE)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req_valid   (req_valid),
        .i_req_data    (req_data),
        .i_req_last    (req_last),
        .o_req_ready   (req_ready),
        .o_tx_valid    (tx_valid),
        .o_tx_data     (tx_data),
        .i_tx_ready    (tx_ready),
        .o_grant_id    (grant_id),
        .o_busy        (busy),
        .o_err_timeout (err_timeout),
        .o_err_cnt     (err_cnt)
    );

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         gap;
    } item_t;

    item_t      drv_q [NUM_REQ][$];
    logic [7:0] exp_q [$];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         xfer_cnt = 0;
    int         to_pulses = 0;
    int         to_cyc = -1;
    int         byte_cyc [256];
    bit         loaded [NUM_REQ];
    int         gapcnt [NUM_REQ];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l, input int gap);
        item_t it;
        it.data = d;
        it.last = l;
        it.gap  = gap;
        drv_q[r].push_back(it);
    endtask

    task automatic exp_hdr(input int r);
        if (HDR_EN) exp_q.push_back(ID_BASE + 8'(r));
    endtask

    function automatic bit drv_empty();
        bit e;
        e = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) if (drv_q[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic wait_drain(input string name, input int max);
        bit done;
        done = 1'b0;
        for (int k = 0; k < max && !done; k++) begin
            @(negedge clk); #1;
            done = (exp_q.size() == 0) && !busy && drv_empty();
        end
        check(name, {31'd0, done}, 32'd1);
        if (!done) exp_q.delete();
    endtask

    // Monitor: a transfer seen at a negedge completes on the following posedge.
    initial begin : monitor
        for (int i = 0; i < 256; i++) byte_cyc[i] = -1;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n === 1'b1) begin
                if (err_timeout) begin
                    to_pulses++;
                    to_cyc = cyc;
                end
                if (req_ready != '0) check("ready_owner", {28'd0, req_ready}, 32'd1 << grant_id);
                if (tx_valid && tx_ready) begin
                    xfer_cnt++;
                    byte_cyc[tx_data] = cyc;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_unexpected: got %0h expected none", tx_data);
                    end else begin
                        check("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    initial begin : driver
        logic [NUM_REQ-1:0] acc;
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc[i] && drv_q[i].size() > 0) begin
                    void'(drv_q[i].pop_front());
                    loaded[i] = 1'b0;
                end
                if (drv_q[i].size() == 0) begin
                    req_valid[i] = 1'b0;
                    loaded[i]    = 1'b0;
                end else begin
                    if (!loaded[i]) begin
                        gapcnt[i] = drv_q[i][0].gap;
                        loaded[i] = 1'b1;
                    end
                    if (gapcnt[i] > 0) begin
                        gapcnt[i]--;
                        req_valid[i] = 1'b0;
                    end else begin
                        req_valid[i]        = 1'b1;
                        req_data[i*8 +: 8]  = drv_q[i][0].data;
                        req_last[i]         = drv_q[i][0].last;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : main
        int base;
        int bad;
        bit seen;
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_ready  = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_req_ready", {28'd0, req_ready}, 32'd0);
        check("rst_grant", {30'd0, grant_id}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err_to", {31'd0, err_timeout}, 32'd0);
        check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Test 1: single message, one-cycle grant latency
        @(posedge clk); #2;
        push(0, 8'h11, 1'b0, 0); push(0, 8'h22, 1'b0, 0); push(0, 8'h33, 1'b1, 0);
        exp_hdr(0); exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
        seen = 1'b0;
        for (int k = 0; k < 5 && !seen; k++) begin
            @(negedge clk); #1;
            seen = req_valid[0];
        end
        check("t1_valid_seen", {31'd0, seen}, 32'd1);
        check("t1_idle_tx_valid", {31'd0, tx_valid}, 32'd0);
        @(negedge clk); #1;
        check("t1_latency_tx_valid", {31'd0, tx_valid}, 32'd1);
        check("t1_grant", {30'd0, grant_id}, 32'd0);
        check("t1_busy", {31'd0, busy}, 32'd1);
        wait_drain("t1_drain", 50);

        // Test 2: Req1 and Req3 together, Req1 first
        @(posedge clk); #2;
        push(1, 8'h41, 1'b0, 0); push(1, 8'h42, 1'b1, 0);
        push(3, 8'h61, 1'b0, 0); push(3, 8'h62, 1'b1, 0);
        exp_hdr(1); exp_q.push_back(8'h41); exp_q.push_back(8'h42);
        exp_hdr(3); exp_q.push_back(8'h61); exp_q.push_back(8'h62);
        wait_drain("t2_drain", 50);
        check("t2_err_cnt", {24'd0, err_cnt}, 32'd0);

        // Test 3: Req2 stalls mid-message, timeout revokes, Req0 next
        @(posedge clk); #2;
        push(2, 8'h21, 1'b0, 0); push(2, 8'h22, 1'b1, 1100);
        exp_hdr(2); exp_q.push_back(8'h21);
        repeat (10) @(posedge clk);
        #2;
        push(0, 8'h01, 1'b0, 0); push(0, 8'h02, 1'b1, 0);
        exp_hdr(0); exp_q.push_back(8'h01); exp_q.push_back(8'h02);
        exp_hdr(2); exp_q.push_back(8'h22);
        seen = 1'b0;
        for (int k = 0; k < 1200 && !seen; k++) begin
            @(negedge clk); #1;
            seen = (to_pulses > 0);
        end
        check("t3_timeout_seen", {31'd0, seen}, 32'd1);
        check("t3_timeout_latency", to_cyc - byte_cyc[8'h21], TIMEOUT);
        @(negedge clk); #1;
        check("t3_idle_after_to", {31'd0, busy}, 32'd0);
        check("t3_err_cnt", {24'd0, err_cnt}, 32'd1);
        @(negedge clk); #1;
        check("t3_regrant_busy", {31'd0, busy}, 32'd1);
        check("t3_regrant_id", {30'd0, grant_id}, 32'd0);
        wait_drain("t3_drain", 1300);
        check("t3_one_pulse", to_pulses, 1);

        // Test 4: long TxReady backpressure mid-message
        @(posedge clk); #2;
        base = xfer_cnt;
        push(0, 8'h71, 1'b0, 0); push(0, 8'h72, 1'b0, 0); push(0, 8'h73, 1'b1, 0);
        exp_hdr(0); exp_q.push_back(8'h71); exp_q.push_back(8'h72); exp_q.push_back(8'h73);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk); #1;
            seen = (xfer_cnt >= base + (HDR_EN ? 2 : 1));
        end
        check("t4_first_byte", {31'd0, seen}, 32'd1);
        @(posedge clk); #2;
        tx_ready = 1'b0;
        base = xfer_cnt;
        bad  = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk); #1;
            if (req_ready != '0 || tx_valid !== 1'b1 || busy !== 1'b1) bad++;
        end
        check("t4_stall_clean", bad, 0);
        check("t4_no_xfer", xfer_cnt, base);
        check("t4_no_timeout", to_pulses, 1);
        check("t4_err_cnt", {24'd0, err_cnt}, 32'd1);
        @(posedge clk); #2;
        tx_ready = 1'b1;
        wait_drain("t4_drain", 50);

        // Test 5: Req2 single byte with the first offered byte stalled
        @(posedge clk); #2;
        tx_ready = 1'b0;
        base = xfer_cnt;
        push(2, 8'h55, 1'b1, 0);
        exp_hdr(2); exp_q.push_back(8'h55);
        repeat (5) @(negedge clk);
        #1;
        check("t5_stall_valid", {31'd0, tx_valid}, 32'd1);
        check("t5_stall_data", {24'd0, tx_data}, HDR_EN ? 32'hA2 : 32'h55);
        check("t5_stall_grant", {30'd0, grant_id}, 32'd2);
        check("t5_no_xfer", xfer_cnt, base);
        @(posedge clk); #2;
        tx_ready = 1'b1;
        wait_drain("t5_drain", 50);

        // Test 6: reset mid-message, then Req0 beats Req1
        @(posedge clk); #2;
        push(1, 8'h81, 1'b0, 0); push(1, 8'h82, 1'b0, 3); push(1, 8'h83, 1'b1, 0);
        exp_hdr(1); exp_q.push_back(8'h81);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk); #1;
            seen = (byte_cyc[8'h81] >= 0);
        end
        check("t6_first_byte", {31'd0, seen}, 32'd1);
        @(posedge clk); #2;
        check("t6_busy_before_rst", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) drv_q[i].delete();
        req_valid = '0;
        #1;
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("t6_rst_req_ready", {28'd0, req_ready}, 32'd0);
        check("t6_rst_grant", {30'd0, grant_id}, 32'd0);
        check("t6_rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        check("t6_exp_empty", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
        push(0, 8'h91, 1'b1, 0);
        push(1, 8'h92, 1'b1, 0);
        exp_hdr(0); exp_q.push_back(8'h91);
        exp_hdr(1); exp_q.push_back(8'h92);
        wait_drain("t6_drain", 50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
